fir_accumulate_tree: RTL and testbench

//   Consumes the flat per-tap product vector from the FIR multiply stage and reduces it
//   to one filter output sample per accepted input beat.
//   - Pipelined, registered binary adder tree.
//   - Followed by a round/shift/saturate output stage.
//   - valid/ready handshake on both sides; sits between the multiply array and the FIR output port.

---
 rtl/fir_pkg.sv | 43 ++++
 rtl/fir_accumulate_tree_if.sv | 23 ++
 rtl/fir_add_stage.sv | 51 +++++
 rtl/fir_accumulate_tree.sv | 106 ++++++++++
 tb/tb_fir_accumulate_tree.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared helpers for the FIR datapath: width arithmetic and the round/shift/saturate step.
package fir_pkg;

    localparam int SUM_MAX_W = 64;
    localparam int Y_MAX_W   = 32;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r++;
        end
        return r;
    endfunction

    function automatic int acc_width(input int width, input int taps);
        return 2 * width + clog2(taps);
    endfunction

    // Returns {sat, y}; y occupies the low `width` bits of the lower Y_MAX_W field.
    function automatic logic [Y_MAX_W:0] sat_round(input logic signed [SUM_MAX_W-1:0] sum,
                                                   input int shift, input int width);
        logic signed [SUM_MAX_W-1:0] r;
        logic signed [SUM_MAX_W-1:0] hi;
        logic signed [SUM_MAX_W-1:0] lo;
        logic [Y_MAX_W:0] res;
        r  = (sum + (64'sd1 <<< (shift - 1))) >>> shift;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (r > hi) begin
            res = {1'b1, 32'(hi)};
        end else if (r < lo) begin
            res = {1'b1, 32'(lo)};
        end else begin
            res = {1'b0, 32'(r)};
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_accumulate_tree_if.sv
// Handshake bundle between the multiply array, the accumulate tree and the FIR output port.
interface fir_accumulate_tree_if #(
    parameter int WIDTH = 16,
    parameter int TAPS  = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic [TAPS*2*WIDTH-1:0] products_flat;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        y_out;
    logic                    sat;

    modport master (
        output in_valid, products_flat, out_ready,
        input  in_ready, out_valid, y_out, sat
    );

    modport slave (
        input  in_valid, products_flat, out_ready,
        output in_ready, out_valid, y_out, sat
    );
endinterface

// File: rtl/fir_add_stage.sv
// One registered level of the adder tree: pairwise signed adds with one bit of growth.
module fir_add_stage #(
    parameter int N_IN = 2,
    parameter int W_IN = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en_i,
    input  logic                            vld_i,
    input  logic [N_IN*W_IN-1:0]            din_i,
    output logic                            vld_o,
    output logic [(N_IN/2)*(W_IN+1)-1:0]    dout_o
);
    localparam int N_OUT = N_IN / 2;
    localparam int W_OUT = W_IN + 1;

    logic [N_OUT*W_OUT-1:0] sum_d;
    logic [N_OUT*W_OUT-1:0] sum_q;
    logic                   vld_q;

    always_comb begin
        logic signed [W_IN-1:0] a;
        logic signed [W_IN-1:0] b;
        sum_d = '0;
        a     = '0;
        b     = '0;
        for (int j = 0; j < N_OUT; j++) begin
            a = din_i[(2*j)*W_IN +: W_IN];
            b = din_i[(2*j+1)*W_IN +: W_IN];
            sum_d[j*W_OUT +: W_OUT] = W_OUT'(a) + W_OUT'(b);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= 1'b0;
        end else if (en_i) begin
            vld_q <= vld_i;
        end
    end

    // Data carries no reset; its valid bit decides whether it means anything.
    always_ff @(posedge clk) begin
        if (en_i) begin
            sum_q <= sum_d;
        end
    end

    assign vld_o  = vld_q;
    assign dout_o = sum_q;
endmodule

// File: rtl/fir_accumulate_tree.sv
// Reduces the per-tap product vector to one rounded, saturated FIR output per accepted beat.
module fir_accumulate_tree
    import fir_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAPS  = 8,
    parameter int SHIFT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    fir_accumulate_tree_if.slave  bus
);
    localparam int LVL   = clog2(TAPS);
    localparam int NP    = 1 << LVL;
    localparam int PW    = 2 * WIDTH;
    localparam int ACC_W = acc_width(WIDTH, TAPS);

    logic                    stall;
    logic                    accept;
    logic [NP*PW-1:0]        leaves;
    logic signed [ACC_W-1:0] sum_w;
    logic                    sum_vld;
    logic [Y_MAX_W:0]        rnd;
    logic                    unused_rnd;

    logic                    out_valid_d, out_valid_q;
    logic [WIDTH-1:0]        y_d, y_q;
    logic                    sat_d, sat_q;

    // Reset overrides backpressure so the pipe always flushes and in_ready stays high.
    assign stall  = out_valid_q & ~bus.out_ready & ~rst;
    assign accept = bus.in_valid & ~stall;

    always_comb begin
        leaves = '0;
        for (int i = 0; i < TAPS; i++) begin
            leaves[i*PW +: PW] = bus.products_flat[i*PW +: PW];
        end
    end

    for (genvar l = 0; l < LVL; l++) begin : g_lvl
        localparam int NI = NP >> l;
        localparam int WI = PW + l;

        logic [NI*WI-1:0]           din;
        logic                       vin;
        logic [(NI/2)*(WI+1)-1:0]   dout;
        logic                       vout;

        if (l == 0) begin : g_first
            assign din = leaves;
            assign vin = accept;
        end else begin : g_next
            assign din = g_lvl[l-1].dout;
            assign vin = g_lvl[l-1].vout;
        end

        fir_add_stage #(
            .N_IN (NI),
            .W_IN (WI)
        ) u_stage (
            .clk    (clk),
            .rst    (rst),
            .en_i   (~stall),
            .vld_i  (vin),
            .din_i  (din),
            .vld_o  (vout),
            .dout_o (dout)
        );
    end

    assign sum_w   = g_lvl[LVL-1].dout;
    assign sum_vld = g_lvl[LVL-1].vout;

    // Output stage: round, shift and clip the exact tree sum.
    assign rnd        = sat_round(64'(sum_w), SHIFT, WIDTH);
    assign unused_rnd = ^rnd;

    always_comb begin
        out_valid_d = out_valid_q;
        y_d         = y_q;
        sat_d       = sat_q;
        if (!stall) begin
            out_valid_d = sum_vld;
            y_d         = rnd[WIDTH-1:0];
            sat_d       = rnd[Y_MAX_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            y_q         <= '0;
            sat_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            sat_q       <= sat_d;
        end
    end

    assign bus.in_ready  = ~stall;
    assign bus.out_valid = out_valid_q;
    assign bus.y_out     = y_q;
    assign bus.sat       = sat_q;
endmodule

// File: tb/tb_fir_accumulate_tree.sv
// Directed bench for fir_accumulate_tree at WIDTH=16, TAPS=8, SHIFT=15.
module tb_fir_accumulate_tree;
    localparam int WIDTH = 16;
    localparam int TAPS  = 8;
    localparam int SHIFT = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fir_accumulate_tree_if #(.WIDTH(WIDTH), .TAPS(TAPS)) bus ();

    fir_accumulate_tree #(.WIDTH(WIDTH), .TAPS(TAPS), .SHIFT(SHIFT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    logic signed [31:0] prod [TAPS];
    logic [16:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Independent golden model: exact sum, +half, arithmetic shift, clip.
    function automatic logic [16:0] model();
        longint s;
        longint r;
        s = 0;
        for (int k = 0; k < TAPS; k++) s += longint'(prod[k]);
        r = (s + 64'sd16384) >>> 15;
        if (r > 32767)  return {1'b1, 16'h7fff};
        if (r < -32768) return {1'b1, 16'h8000};
        return {1'b0, r[15:0]};
    endfunction

    task automatic drive_beat();
        for (int k = 0; k < TAPS; k++) bus.products_flat[k*32 +: 32] = prod[k];
        bus.in_valid = 1'b1;
    endtask

    task automatic set_all(input logic signed [31:0] v);
        for (int k = 0; k < TAPS; k++) prod[k] = v;
    endtask

    task automatic set_first(input logic signed [31:0] v);
        for (int k = 0; k < TAPS; k++) prod[k] = 32'sd0;
        prod[0] = v;
    endtask

    task automatic gen(input int seed, input int b);
        longint a;
        longint c;
        for (int k = 0; k < TAPS; k++) begin
            a = ((b * 7919 + k * 104729 + seed) % 65536) - 32768;
            c = ((k * 31 + b * 17 + seed * 3) % 65536) - 32768;
            prod[k] = 32'(a * c);
        end
    endtask

    // Sends one beat into an empty pipe and checks latency and the result.
    task automatic send_one(input string tag, input logic [15:0] ey, input logic es, input logic drop_rdy);
        logic [3:0] seen;
        seen = '0;
        drive_beat();
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (k == 0) bus.in_valid = 1'b0;
            bus.out_ready = (k < 2) ? ~drop_rdy : 1'b1;
            seen[k] = bus.out_valid;
        end
        chk({tag, "_latency"}, {28'd0, seen}, 32'h8);
        chk({tag, "_y"}, {16'd0, bus.y_out}, {16'd0, ey});
        chk({tag, "_sat"}, {31'd0, bus.sat}, {31'd0, es});
        @(posedge clk); #1;
    endtask

    task automatic stream(input string tag, input int n, input int seed, input int st_start, input int st_len);
        int b, got, cyc, first, last, stall_seen;
        logic was_stall;
        logic [15:0] held;
        logic [16:0] e;
        b = 0; got = 0; cyc = 0; first = -1; last = -1; stall_seen = 0;
        was_stall = 1'b0; held = '0;
        exp_q.delete();
        while (got < n && cyc < 200) begin
            bus.out_ready = !(cyc >= st_start && cyc < st_start + st_len);
            if (b < n) begin
                gen(seed, b);
                drive_beat();
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            if (bus.out_valid && !bus.out_ready) begin
                chk({tag, "_in_ready_stalled"}, {31'd0, bus.in_ready}, 32'd0);
                if (was_stall) chk({tag, "_y_hold"}, {16'd0, bus.y_out}, {16'd0, held});
                held = bus.y_out;
                was_stall = 1'b1;
                stall_seen++;
            end else begin
                was_stall = 1'b0;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model());
                b++;
            end
            if (bus.out_valid && bus.out_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 17'h1ffff;
                chk($sformatf("%s_out%0d", tag, got), {15'd0, bus.sat, bus.y_out}, {15'd0, e});
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        chk({tag, "_count"}, got, n);
        chk({tag, "_leftover"}, exp_q.size(), 0);
        if (st_len == 0) chk({tag, "_consecutive"}, last - first + 1, n);
        else             chk({tag, "_stall_cycles"}, stall_seen, st_len);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timed out");
    end

    initial begin
        int vcount;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.products_flat = '0;
        set_all(32'sd0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
        rst = 1'b0;
        chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("reset_y", {16'd0, bus.y_out}, 32'd0);
        chk("reset_sat", {31'd0, bus.sat}, 32'd0);

        set_all(32'sh0000_8000);
        send_one("t1_all_half", 16'd8, 1'b0, 1'b1);

        set_first(32'sd16384);
        send_one("t2_round_up", 16'd1, 1'b0, 1'b0);
        set_first(-32'sd16384);
        send_one("t2_round_half", 16'd0, 1'b0, 1'b0);
        set_first(-32'sd16385);
        send_one("t2_round_neg", 16'hffff, 1'b0, 1'b0);

        set_all(32'sh4000_0000);
        send_one("t3_sat_pos", 16'h7fff, 1'b1, 1'b0);
        set_all(32'shC000_0000);
        send_one("t3_sat_neg", 16'h8000, 1'b1, 1'b0);

        stream("t4_stream", 20, 11, 0, 0);
        stream("t5_bp", 6, 4242, 4, 3);

        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_all(32'sd32768 * (i + 1));
            drive_beat();
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("t6_in_ready_in_reset", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t6_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("t6_y", {16'd0, bus.y_out}, 32'd0);
        chk("t6_sat", {31'd0, bus.sat}, 32'd0);
        vcount = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (bus.out_valid) vcount++;
        end
        chk("t6_flushed", vcount, 0);
        set_all(32'sh0000_8000);
        send_one("t6_fresh", 16'd8, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
